alu_top: RTL and testbench



---
 rtl/alu_top.sv | 150 +++++++++++++++
 tb/tb_alu_top.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_top.sv
// alu_top: RV32 integer ALU started on a rising dat_ready level.
// Result and status flags are registered and hold until the next start.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_SLL  = 5'd2,
    OP_SLT  = 5'd3,
    OP_SLTU = 5'd4,
    OP_XOR  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_OR   = 5'd8,
    OP_AND  = 5'd9,
    OP_BEQ  = 5'd10,
    OP_BNE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BGE  = 5'd13,
    OP_BLTU = 5'd14,
    OP_BGEU = 5'd15,
    OP_PASS = 5'd16
  } alu_op_e;

  typedef struct packed {
    logic [31:0] out;
    logic        ovf;
    logic        con;
    logic        err;
  } alu_res_t;

endpackage

module alu_top
  import alu_pkg::*;
(
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        dat_ready,
  input  logic [31:0] ALU_dat1,
  input  logic [31:0] ALU_dat2,
  input  logic [4:0]  Instruction_to_ALU,
  output logic [31:0] ALU_out,
  output logic        ALU_overflow,
  output logic        ALU_zero,
  output logic        ALU_con_met,
  output logic        ALU_err,
  output logic        ALU_ready
);

  logic        r_dat_ready_q;
  alu_res_t    r_res;
  logic        r_zero;
  logic        r_ready;

  logic        w_start;
  logic [16:0] w_hot;
  logic [4:0]  w_shamt;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;
  logic        w_eq;
  logic        w_lt;
  logic        w_ltu;
  logic        w_add_ovf;
  logic        w_sub_ovf;
  alu_res_t    w_res;

  assign w_start = dat_ready & ~r_dat_ready_q;

  // One-hot opcode; codes 17-31 leave every bit clear and fall to default.
  assign w_hot   = 17'd1 << Instruction_to_ALU;
  assign w_shamt = ALU_dat2[4:0];

  assign w_sum  = ALU_dat1 + ALU_dat2;
  assign w_diff = ALU_dat1 - ALU_dat2;
  assign w_sll  = ALU_dat1 << w_shamt;
  assign w_srl  = ALU_dat1 >> w_shamt;
  assign w_sra  = $signed(ALU_dat1) >>> w_shamt;

  assign w_eq  = (ALU_dat1 == ALU_dat2);
  assign w_lt  = ($signed(ALU_dat1) < $signed(ALU_dat2));
  assign w_ltu = (ALU_dat1 < ALU_dat2);

  assign w_add_ovf = (ALU_dat1[31] == ALU_dat2[31]) &&
                     (w_sum[31] != ALU_dat1[31]);
  assign w_sub_ovf = (ALU_dat1[31] != ALU_dat2[31]) &&
                     (w_diff[31] != ALU_dat1[31]);

  always_comb begin
    w_res = '0;
    unique case (1'b1)
      w_hot[OP_ADD]: begin
        w_res.out = w_sum;
        w_res.ovf = w_add_ovf;
      end
      w_hot[OP_SUB]: begin
        w_res.out = w_diff;
        w_res.ovf = w_sub_ovf;
      end
      w_hot[OP_SLL]:  w_res.out = w_sll;
      w_hot[OP_SLT]:  w_res.out = {31'b0, w_lt};
      w_hot[OP_SLTU]: w_res.out = {31'b0, w_ltu};
      w_hot[OP_XOR]:  w_res.out = ALU_dat1 ^ ALU_dat2;
      w_hot[OP_SRL]:  w_res.out = w_srl;
      w_hot[OP_SRA]:  w_res.out = w_sra;
      w_hot[OP_OR]:   w_res.out = ALU_dat1 | ALU_dat2;
      w_hot[OP_AND]:  w_res.out = ALU_dat1 & ALU_dat2;
      w_hot[OP_BEQ]:  w_res.con = w_eq;
      w_hot[OP_BNE]:  w_res.con = ~w_eq;
      w_hot[OP_BLT]:  w_res.con = w_lt;
      w_hot[OP_BGE]:  w_res.con = ~w_lt;
      w_hot[OP_BLTU]: w_res.con = w_ltu;
      w_hot[OP_BGEU]: w_res.con = ~w_ltu;
      w_hot[OP_PASS]: w_res.out = ALU_dat2;
      default:        w_res.err = 1'b1;
    endcase
    if (w_res.con) begin
      w_res.out = 32'd1;
    end
  end

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      r_dat_ready_q <= 1'b0;
      r_res         <= '0;
      r_zero        <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_dat_ready_q <= dat_ready;
      if (!dat_ready) begin
        r_ready <= 1'b0;
      end else if (w_start) begin
        r_res   <= w_res;
        r_zero  <= (w_res.out == 32'd0);
        r_ready <= 1'b1;
      end
    end
  end

  assign ALU_out      = r_res.out;
  assign ALU_overflow = r_res.ovf;
  assign ALU_con_met  = r_res.con;
  assign ALU_err      = r_res.err;
  assign ALU_zero     = r_zero;
  assign ALU_ready    = r_ready;

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: directed corner cases plus randomized traffic against
// an arithmetic reference model of the edge-started ALU.
module tb_alu_top;

  logic        soc_clk;
  logic        reset;
  logic        dat_ready;
  logic [31:0] ALU_dat1;
  logic [31:0] ALU_dat2;
  logic [4:0]  Instruction_to_ALU;
  logic [31:0] ALU_out;
  logic        ALU_overflow;
  logic        ALU_zero;
  logic        ALU_con_met;
  logic        ALU_err;
  logic        ALU_ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_out;
  logic        m_ovf, m_zero, m_con, m_err, m_rdy, m_prev;

  alu_top u_dut (
    .soc_clk            (soc_clk),
    .reset              (reset),
    .dat_ready          (dat_ready),
    .ALU_dat1           (ALU_dat1),
    .ALU_dat2           (ALU_dat2),
    .Instruction_to_ALU (Instruction_to_ALU),
    .ALU_out            (ALU_out),
    .ALU_overflow       (ALU_overflow),
    .ALU_zero           (ALU_zero),
    .ALU_con_met        (ALU_con_met),
    .ALU_err            (ALU_err),
    .ALU_ready          (ALU_ready)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] o,
    output logic        ov,
    output logic        cm,
    output logic        er
  );
    longint sa, sb, s;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    o = 32'd0; ov = 1'b0; cm = 1'b0; er = 1'b0;
    case (op)
      5'd0: begin
        s  = sa + sb;
        o  = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd1: begin
        s  = sa - sb;
        o  = s[31:0];
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd2:  o = a << sh;
      5'd3:  o = (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  o = (a < b) ? 32'd1 : 32'd0;
      5'd5:  o = a ^ b;
      5'd6:  o = a >> sh;
      5'd7:  o = 32'($signed(a) >>> sh);
      5'd8:  o = a | b;
      5'd9:  o = a & b;
      5'd10: cm = (a == b);
      5'd11: cm = (a != b);
      5'd12: cm = (sa < sb);
      5'd13: cm = (sa >= sb);
      5'd14: cm = (a < b);
      5'd15: cm = (a >= b);
      5'd16: o = b;
      default: er = 1'b1;
    endcase
    if (op >= 5'd10 && op <= 5'd15) o = {31'b0, cm};
  endfunction

  task automatic check_all(input string pfx);
    chk({pfx, " out"},  ALU_out,      m_out);
    chk({pfx, " ovf"},  ALU_overflow, m_ovf);
    chk({pfx, " zero"}, ALU_zero,     m_zero);
    chk({pfx, " con"},  ALU_con_met,  m_con);
    chk({pfx, " err"},  ALU_err,      m_err);
    chk({pfx, " rdy"},  ALU_ready,    m_rdy);
  endtask

  task automatic model_reset();
    m_out = '0; m_ovf = 0; m_zero = 0; m_con = 0;
    m_err = 0; m_rdy = 0; m_prev = 0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string pfx, input logic dr,
                      input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    dat_ready = dr;
    Instruction_to_ALU = op;
    ALU_dat1 = a;
    ALU_dat2 = b;
    @(posedge soc_clk);
    if (dr && !m_prev) begin
      ref_op(op, a, b, m_out, m_ovf, m_con, m_err);
      m_zero = (m_out == 32'd0);
      m_rdy  = 1'b1;
    end else if (!dr) begin
      m_rdy = 1'b0;
    end
    m_prev = dr;
    @(negedge soc_clk);
    check_all(pfx);
  endtask

  task automatic run_op(input string pfx, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    step({pfx, " idle"}, 1'b0, op, a, b);
    step(pfx, 1'b1, op, a, b);
  endtask

  task automatic pulse_reset(input string pfx);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(pfx);
    @(negedge soc_clk);
    reset = 1'b0;
  endtask

  logic [31:0] ra, rb;
  logic [4:0]  rop;
  logic        rdr;

  initial begin
    reset = 1'b1;
    dat_ready = 1'b0;
    ALU_dat1 = '0;
    ALU_dat2 = '0;
    Instruction_to_ALU = '0;
    model_reset();
    repeat (2) @(negedge soc_clk);
    check_all("reset");
    reset = 1'b0;

    run_op("add ovf", 5'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    chk("add ovf const out", ALU_out, 32'h8000_0000);
    chk("add ovf const flag", ALU_overflow, 1'b1);
    chk("add ovf const rdy", ALU_ready, 1'b1);

    run_op("sub zero", 5'd1, 32'd5, 32'd5);
    chk("sub zero const", ALU_zero, 1'b1);
    step("sub drop", 1'b0, 5'd1, 32'd5, 32'd5);
    chk("sub drop rdy", ALU_ready, 1'b0);

    run_op("sra", 5'd7, 32'h8000_0000, 32'h0000_0024);
    chk("sra const", ALU_out, 32'hF800_0000);
    run_op("srl", 5'd6, 32'h8000_0000, 32'h0000_0024);
    chk("srl const", ALU_out, 32'h0800_0000);

    run_op("blt", 5'd12, 32'hFFFF_FFFF, 32'd1);
    chk("blt const", ALU_con_met, 1'b1);
    run_op("bltu", 5'd14, 32'hFFFF_FFFF, 32'd1);
    chk("bltu const", ALU_zero, 1'b1);

    run_op("undef", 5'd20, 32'h1234, 32'h5678);
    chk("undef const err", ALU_err, 1'b1);
    step("undef hold", 1'b1, 5'd0, 32'h1, 32'h2);
    chk("undef hold const", ALU_out, 32'd0);

    run_op("pre-rst", 5'd5, 32'hA5A5_0000, 32'h0000_5A5A);
    pulse_reset("async rst");
    step("post-rst", 1'b1, 5'd16, 32'h0, 32'hCAFE_F00D);
    chk("post-rst const", ALU_out, 32'hCAFE_F00D);

    for (int i = 0; i < 600; i++) begin
      rdr = ($urandom_range(0, 2) != 0);
      rop = 5'($urandom_range(0, 21));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'h7FFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      if ($urandom_range(0, 49) == 0) begin
        dat_ready = rdr;
        pulse_reset("rnd rst");
      end
      step("rnd", rdr, rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
